// File: rtl/mod3_serial_ctrl_if.sv
// Request/result bundle for mod3_serial_ctrl: start/din in, busy/done/z/rem out.
interface mod3_serial_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic             z;
  logic [1:0]       rem;

  modport master (output start, din, input busy, done, z, rem);
  modport slave  (input start, din, output busy, done, z, rem);
endinterface

// File: rtl/mod3_serial_ctrl.sv
// Serial modulo-3 evaluator: one reused mod-3 cell walks the operand LSB first.
// Optional MOD3_EARLY_EXIT_EN ends the walk once the remaining bits are all zero.
module mod3_serial_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  mod3_serial_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINAL, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [1:0]       r;
  logic [1:0]       w;

  logic [2:0]       sum_c;
  logic [1:0]       r_next_c;
  logic             last_c;

  // Iterative cell: add the bit's weight (2^i mod 3), reduce with one subtract.
  always_comb begin
    sum_c    = 3'(r) + (shreg[0] ? 3'(w) : 3'd0);
    r_next_c = (sum_c >= 3'd3) ? 2'(sum_c - 3'd3) : 2'(sum_c);
`ifdef MOD3_EARLY_EXIT_EN
    last_c   = (cnt == CW'(WIDTH - 1)) || (shreg[WIDTH-1:1] == '0);
`else
    last_c   = (cnt == CW'(WIDTH - 1));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy_q_reset();
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg    <= bus.din;
            r        <= 2'd0;
            w        <= 2'd1;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          r     <= r_next_c;
          w     <= (w == 2'd1) ? 2'd2 : 2'd1;
          shreg <= shreg >> 1;
          cnt   <= cnt + CW'(1);
          if (last_c) state <= FINAL;
        end
        FINAL: begin
          bus.rem  <= r;
          bus.z    <= (r == 2'd0);
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          // Back-to-back: a start seen here is accepted like in IDLE.
          if (bus.start) begin
            shreg    <= bus.din;
            r        <= 2'd0;
            w        <= 2'd1;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset values shared by every register of the controller.
  task automatic busy_q_reset();
    bus.busy <= 1'b0;
    bus.done <= 1'b0;
    bus.z    <= 1'b0;
    bus.rem  <= 2'd0;
    shreg    <= '0;
    cnt      <= '0;
    r        <= 2'd0;
    w        <= 2'd1;
  endtask
endmodule

// File: tb/tb_mod3_serial_ctrl.sv
// Directed + exhaustive bench for mod3_serial_ctrl with a result scoreboard.
module tb_mod3_serial_ctrl;
  localparam int unsigned W8 = 8;
  localparam int unsigned W5 = 5;
  localparam int unsigned W2 = 2;

  typedef struct packed {
    logic [1:0] rem;
    logic       z;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;
  int   done_cnt;
  int   t_acc;
  exp_t sb[$];
  exp_t mon_e;

  mod3_serial_ctrl_if #(.WIDTH(W8)) bus8 ();
  mod3_serial_ctrl_if #(.WIDTH(W5)) bus5 ();
  mod3_serial_ctrl_if #(.WIDTH(W2)) bus2 ();

  mod3_serial_ctrl #(.WIDTH(W8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  mod3_serial_ctrl #(.WIDTH(W5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));
  mod3_serial_ctrl #(.WIDTH(W2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t model(input int d);
    exp_t e;
    e.rem = 2'(d % 3);
    e.z   = (d % 3 == 0);
    return e;
  endfunction

  // Cycles from the accepting edge to done for a W8 operand.
  function automatic int lat8(input int d);
`ifdef MOD3_EARLY_EXIT_EN
    int h;
    h = 0;
    for (int i = 0; i < int'(W8); i++) if (d[i]) h = i;
    return h + 2;
`else
    return int'(W8) + 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (!rst && bus8.done === 1'b1) begin
      done_cnt++;
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("rem", 32'(bus8.rem), 32'(mon_e.rem));
        check("z", 32'(bus8.z), 32'(mon_e.z));
      end
    end
  end

  task automatic go8(input int d, input bit push);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.din   = W8'(d);
    if (push) sb.push_back(model(d));
    @(posedge clk);
    #1;
    t_acc      = cyc;
    bus8.start = 1'b0;
  endtask

  task automatic wait_done8(output int lat, output int nbusy);
    int n;
    n     = 0;
    nbusy = (bus8.busy === 1'b1) ? 1 : 0;
    while (bus8.done !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (bus8.busy === 1'b1 && bus8.done !== 1'b1) nbusy++;
    end
    check("done_seen", 32'(bus8.done), 32'd1);
    lat = cyc - t_acc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb, dc0, t0, t1, t2, n;
    tests = 0; fails = 0; cyc = 0; done_cnt = 0; t_acc = 0;
    rst = 1'b1;
    bus8.start = 1'b0; bus8.din = '0;
    bus5.start = 1'b0; bus5.din = '0;
    bus2.start = 1'b0; bus2.din = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_z", 32'(bus8.z), 32'd0);
    check("rst_rem", 32'(bus8.rem), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single operand 9: latency, busy width, one-cycle done.
    go8(9, 1'b1);
    wait_done8(lat, nb);
    check("lat_9", 32'(lat), 32'(lat8(9)));
    check("busy_cycles_9", 32'(nb), 32'(lat8(9)));
    @(posedge clk);
    #1;
    check("done_pulse_9", 32'(bus8.done), 32'd0);

    // Back-to-back 10, 128, 255 with start held through DONE.
    dc0 = done_cnt;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.din   = W8'(10);
    sb.push_back(model(10));
    @(posedge clk);
    #1;
    t_acc    = cyc;
    bus8.din = W8'(128);
    wait_done8(lat, nb);
    check("b2b_lat_10", 32'(lat), 32'(lat8(10)));
    t0 = cyc;
    sb.push_back(model(128));
    @(posedge clk);
    #1;
    t_acc    = cyc;
    bus8.din = W8'(255);
    check("b2b_reaccept_busy", 32'(bus8.busy), 32'd1);
    check("b2b_done_drop", 32'(bus8.done), 32'd0);
    wait_done8(lat, nb);
    t1 = cyc;
    check("b2b_spacing_1", 32'(t1 - t0), 32'(lat8(128) + 1));
    sb.push_back(model(255));
    @(posedge clk);
    #1;
    t_acc      = cyc;
    bus8.start = 1'b0;
    wait_done8(lat, nb);
    t2 = cyc;
    check("b2b_spacing_2", 32'(t2 - t1), 32'(lat8(255) + 1));
    @(posedge clk);
    #1;
    check("b2b_idle_busy", 32'(bus8.busy), 32'd0);
    check("b2b_done_count", 32'(done_cnt - dc0), 32'd3);

    // Start toggled mid-operation is ignored.
    dc0 = done_cnt;
    go8(7, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.din   = W8'(5);
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8(lat, nb);
    check("ign_lat_7", 32'(lat), 32'(lat8(7)));
    repeat (12) @(posedge clk);
    #1;
    check("ign_done_count", 32'(done_cnt - dc0), 32'd1);
    check("ign_idle_busy", 32'(bus8.busy), 32'd0);

    // Asynchronous reset mid-SHIFT clears everything and suppresses done.
    dc0 = done_cnt;
    go8(9, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(bus8.busy), 32'd0);
    check("arst_done", 32'(bus8.done), 32'd0);
    check("arst_z", 32'(bus8.z), 32'd0);
    check("arst_rem", 32'(bus8.rem), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("arst_no_done", 32'(done_cnt - dc0), 32'd0);
    go8(6, 1'b1);
    wait_done8(lat, nb);
    check("post_rst_z_6", 32'(bus8.z), 32'd1);

    // Exhaustive W8 through the scoreboard.
    for (int d = 0; d < 256; d++) begin
      go8(d, 1'b1);
      wait_done8(lat, nb);
      check("ex8_lat", 32'(lat), 32'(lat8(d)));
    end

    // Exhaustive W2 and W5.
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      bus2.start = 1'b1;
      bus2.din   = W2'(d);
      @(posedge clk);
      #1;
      bus2.start = 1'b0;
      n = 0;
      while (bus2.done !== 1'b1 && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("w2_done", 32'(bus2.done), 32'd1);
      check("w2_rem", 32'(bus2.rem), 32'(d % 3));
      check("w2_z", 32'(bus2.z), 32'(d % 3 == 0));
    end
    for (int d = 0; d < 32; d++) begin
      @(negedge clk);
      bus5.start = 1'b1;
      bus5.din   = W5'(d);
      @(posedge clk);
      #1;
      bus5.start = 1'b0;
      n = 0;
      while (bus5.done !== 1'b1 && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("w5_done", 32'(bus5.done), 32'd1);
      check("w5_rem", 32'(bus5.rem), 32'(d % 3));
      check("w5_z", 32'(bus5.z), 32'(d % 3 == 0));
    end

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
